// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: column-strobed 4x3 keypad scanner with a 2-FF row
// synchronizer, per-scan single-key decode (multi-key presses decode as no
// key), whole-scan debounce, and registered one-hot digit, '*' and '#' outputs.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] row_n,
    output logic [2:0] col_n,
    output logic [9:0] keypad,
    output logic       key_star,
    output logic       key_hash,
    output logic       key_strobe
);

    localparam int                SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                CNT_W     = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [3:0]        CODE_STAR = 4'd10;
    localparam logic [3:0]        CODE_HASH = 4'd11;
    localparam logic [3:0]        CODE_NONE = 4'd15;

    // Snapshot bit index is row*3 + col; translate it to the printed legend.
    function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8: code = idx + 4'd1;
            4'd9:                   code = CODE_STAR;
            4'd10:                  code = 4'd0;
            4'd11:                  code = CODE_HASH;
            default:                code = CODE_NONE;
        endcase
        return code;
    endfunction

    // Exactly one pressed key yields its code; none or several yield NONE.
    function automatic logic [3:0] scan_code(input logic [11:0] snap);
        logic [3:0] hits;
        logic [3:0] idx;
        hits = 4'd0;
        idx  = 4'd0;
        for (int i = 0; i < 12; i++) begin
            hits = hits + {3'b000, snap[i]};
            if (snap[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        if (hits == 4'd1) begin
            return idx_to_code(idx);
        end else begin
            return CODE_NONE;
        end
    endfunction

    // Digit codes map to one keypad bit; '*', '#' and NONE map to zero.
    function automatic logic [9:0] digit_onehot(input logic [3:0] code);
        logic [9:0] onehot;
        onehot = 10'd0;
        if (code < 4'd10) begin
            onehot[code] = 1'b1;
        end else begin
            onehot = 10'd0;
        end
        return onehot;
    endfunction

    logic [3:0]        row_sync1_r;
    logic [3:0]        row_sync2_r;
    logic [SLOT_W-1:0] slot_r;
    logic [1:0]        col_idx_r;
    logic [2:0]        col_n_r;
    logic [11:0]       snap_r;
    logic [3:0]        cand_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [3:0]        stable_r;
    logic [9:0]        keypad_r;
    logic              key_star_r;
    logic              key_hash_r;
    logic              key_strobe_r;

    logic              sample_s;
    logic              scan_done_s;
    logic [1:0]        col_idx_next_s;
    logic [11:0]       snap_merged_s;
    logic [3:0]        code_s;
    logic [3:0]        cand_next_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [3:0]        stable_next_s;

    assign sample_s    = (slot_r == SLOT_LAST);
    assign scan_done_s = sample_s && (col_idx_r == 2'd2);
    assign code_s      = scan_code(snap_merged_s);

    assign col_n      = col_n_r;
    assign keypad     = keypad_r;
    assign key_star   = key_star_r;
    assign key_hash   = key_hash_r;
    assign key_strobe = key_strobe_r;

    // Next column index, wrapping after the rightmost column.
    always_comb begin
        if (col_idx_r == 2'd2) begin
            col_idx_next_s = 2'd0;
        end else begin
            col_idx_next_s = col_idx_r + 2'd1;
        end
    end

    // Snapshot as it will be once the current column's rows are captured.
    always_comb begin
        snap_merged_s = snap_r;
        for (int r = 0; r < 4; r++) begin
            case (col_idx_r)
                2'd0:    snap_merged_s[r*3]     = ~row_sync2_r[r];
                2'd1:    snap_merged_s[r*3 + 1] = ~row_sync2_r[r];
                2'd2:    snap_merged_s[r*3 + 2] = ~row_sync2_r[r];
                default: snap_merged_s[r*3]     = snap_r[r*3];
            endcase
        end
    end

    // Debounce step applied when a scan completes.
    always_comb begin
        if (code_s == cand_r) begin
            cand_next_s = cand_r;
            if (cnt_r < CNT_MAX) begin
                cnt_next_s = cnt_r + CNT_W'(1);
            end else begin
                cnt_next_s = cnt_r;
            end
        end else begin
            cand_next_s = code_s;
            cnt_next_s  = CNT_W'(1);
        end
        if ((cnt_next_s == CNT_MAX) && (cand_next_s != stable_r)) begin
            stable_next_s = cand_next_s;
        end else begin
            stable_next_s = stable_r;
        end
    end

    // Two-stage synchronizer for the asynchronous row inputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            row_sync1_r <= 4'b1111;
            row_sync2_r <= 4'b1111;
        end else begin
            row_sync1_r <= row_n;
            row_sync2_r <= row_sync1_r;
        end
    end

    // Column slot timing, column strobe and snapshot capture at slot end.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            slot_r    <= '0;
            col_idx_r <= 2'd0;
            col_n_r   <= 3'b110;
            snap_r    <= 12'd0;
        end else if (sample_s) begin
            slot_r    <= '0;
            col_idx_r <= col_idx_next_s;
            snap_r    <= snap_merged_s;
            case (col_idx_next_s)
                2'd0:    col_n_r <= 3'b110;
                2'd1:    col_n_r <= 3'b101;
                2'd2:    col_n_r <= 3'b011;
                default: col_n_r <= 3'b110;
            endcase
        end else begin
            slot_r <= slot_r + SLOT_W'(1);
        end
    end

    // Debounce state and registered outputs, updated once per completed scan.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cand_r       <= CODE_NONE;
            cnt_r        <= '0;
            stable_r     <= CODE_NONE;
            keypad_r     <= 10'd0;
            key_star_r   <= 1'b0;
            key_hash_r   <= 1'b0;
            key_strobe_r <= 1'b0;
        end else if (scan_done_s) begin
            cand_r       <= cand_next_s;
            cnt_r        <= cnt_next_s;
            stable_r     <= stable_next_s;
            keypad_r     <= digit_onehot(stable_next_s);
            key_star_r   <= (stable_next_s == CODE_STAR);
            key_hash_r   <= (stable_next_s == CODE_HASH);
            key_strobe_r <= (stable_r == CODE_NONE) && (stable_next_s != CODE_NONE);
        end else begin
            key_strobe_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3.
// Each window starts right after a scan-completing edge, so a key pattern set
// there is fully seen by the next scan and reported after three scans (36 clocks).
module tb_keypad_matrix_scanner;

    logic       clock = 1'b0;
    logic       resetn;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [9:0] keypad;
    logic       key_star;
    logic       key_hash;
    logic       key_strobe;

    logic [11:0] pressed;   // bit row*3+col = key held
    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    int overlap_cnt = 0;

    typedef struct {
        logic [11:0] keys;
        int          cycles;
        logic [9:0]  exp_keypad;
        logic        exp_star;
        logic        exp_hash;
        int          exp_strobes;
    } vec_t;

    vec_t vecs[15];

    keypad_matrix_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .row_n      (row_n),
        .col_n      (col_n),
        .keypad     (keypad),
        .key_star   (key_star),
        .key_hash   (key_hash),
        .key_strobe (key_strobe)
    );

    always #5 clock = ~clock;

    // Membrane keypad: a held key pulls its row low while its column is driven low.
    always_comb begin
        row_n = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (pressed[r*3 + c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (key_strobe === 1'b1) strobe_cnt++;
            if (($countones(keypad) + int'(key_star) + int'(key_hash)) > 1) overlap_cnt++;
        end
    endtask

    initial begin
        logic [2:0] exp_col;

        vecs[0]  = '{12'h000, 24, 10'h000, 1'b0, 1'b0, 0};
        vecs[1]  = '{12'h010, 24, 10'h000, 1'b0, 1'b0, 0};  // key 5, two scans only
        vecs[2]  = '{12'h010, 12, 10'h020, 1'b0, 1'b0, 1};  // third scan reports
        vecs[3]  = '{12'h010, 24, 10'h020, 1'b0, 1'b0, 0};  // held
        vecs[4]  = '{12'h000, 24, 10'h020, 1'b0, 1'b0, 0};  // release, two scans
        vecs[5]  = '{12'h000, 12, 10'h000, 1'b0, 1'b0, 0};  // cleared, no strobe
        vecs[6]  = '{12'h003, 48, 10'h000, 1'b0, 1'b0, 0};  // 1+2 together rejected
        vecs[7]  = '{12'h001, 36, 10'h002, 1'b0, 1'b0, 1};  // release 2, keep 1
        vecs[8]  = '{12'h200, 24, 10'h002, 1'b0, 1'b0, 0};  // '*' not yet stable
        vecs[9]  = '{12'h200, 12, 10'h000, 1'b1, 1'b0, 0};  // direct 1 -> '*'
        vecs[10] = '{12'h800, 36, 10'h000, 1'b0, 1'b1, 0};  // direct '*' -> '#'
        vecs[11] = '{12'h000, 36, 10'h000, 1'b0, 1'b0, 0};
        vecs[12] = '{12'h040, 36, 10'h080, 1'b0, 1'b0, 1};  // key 7
        vecs[13] = '{12'h080, 36, 10'h100, 1'b0, 1'b0, 0};  // direct 7 -> 8
        vecs[14] = '{12'h000, 36, 10'h000, 1'b0, 1'b0, 0};

        resetn  = 1'b0;
        pressed = 12'h000;
        repeat (3) @(negedge clock);
        check_val("reset col_n", 32'(col_n), 32'(3'b110));
        check_val("reset keypad", 32'(keypad), 32'd0);
        check_val("reset star", 32'(key_star), 32'd0);
        check_val("reset hash", 32'(key_hash), 32'd0);
        check_val("reset strobe", 32'(key_strobe), 32'd0);
        resetn = 1'b1;

        // Column strobe sequence: four clocks per column, starting at col0.
        for (int k = 1; k <= 12; k++) begin
            run_cycles(1);
            case ((k / 4) % 3)
                0:       exp_col = 3'b110;
                1:       exp_col = 3'b101;
                default: exp_col = 3'b011;
            endcase
            check_val($sformatf("col_n after edge %0d", k), 32'(col_n), 32'(exp_col));
        end
        check_val("idle strobes", strobe_cnt, 0);

        // One-cycle glitch on key 4 that settles before the col0 sample edge.
        strobe_cnt = 0;
        for (int w = 0; w < 3; w++) begin
            pressed = 12'h008;
            run_cycles(1);
            pressed = 12'h000;
            run_cycles(11);
        end
        check_val("glitch keypad", 32'(keypad), 32'd0);
        check_val("glitch strobes", strobe_cnt, 0);

        for (int i = 0; i < 15; i++) begin
            pressed    = vecs[i].keys;
            strobe_cnt = 0;
            run_cycles(vecs[i].cycles);
            check_val($sformatf("vec%0d keypad", i), 32'(keypad), 32'(vecs[i].exp_keypad));
            check_val($sformatf("vec%0d star", i), 32'(key_star), 32'(vecs[i].exp_star));
            check_val($sformatf("vec%0d hash", i), 32'(key_hash), 32'(vecs[i].exp_hash));
            check_val($sformatf("vec%0d strobes", i), strobe_cnt, vecs[i].exp_strobes);
            check_val($sformatf("vec%0d col_n", i), 32'(col_n), 32'(3'b110));
        end

        // Key 0 bouncing between scans, then settling.
        strobe_cnt = 0;
        for (int w = 0; w < 4; w++) begin
            pressed = (w % 2 == 0) ? 12'h400 : 12'h000;
            run_cycles(12);
            check_val($sformatf("bounce scan %0d keypad", w), 32'(keypad), 32'd0);
        end
        pressed = 12'h400;
        run_cycles(24);
        check_val("settle 2 scans keypad", 32'(keypad), 32'd0);
        run_cycles(12);
        check_val("settle 3 scans keypad", 32'(keypad), 32'(10'h001));
        check_val("bounce strobes", strobe_cnt, 1);
        pressed = 12'h000;
        run_cycles(36);
        check_val("key0 release", 32'(keypad), 32'd0);

        // Key 9 reported, then reset mid-scan while it stays held.
        pressed    = 12'h100;
        strobe_cnt = 0;
        run_cycles(36);
        check_val("key9 keypad", 32'(keypad), 32'(10'h200));
        check_val("key9 strobes", strobe_cnt, 1);
        run_cycles(5);
        #2 resetn = 1'b0;
        #1;
        check_val("async reset col_n", 32'(col_n), 32'(3'b110));
        check_val("async reset keypad", 32'(keypad), 32'd0);
        check_val("async reset strobe", 32'(key_strobe), 32'd0);
        repeat (2) @(negedge clock);
        resetn     = 1'b1;
        strobe_cnt = 0;
        run_cycles(24);
        check_val("post-reset early keypad", 32'(keypad), 32'd0);
        run_cycles(12);
        check_val("post-reset keypad", 32'(keypad), 32'(10'h200));
        check_val("post-reset strobes", strobe_cnt, 1);

        check_val("one output at a time", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
